// File: rtl/mpf_vtp_svc_tag_arb.sv
// mpf_vtp_svc_tag_arb
// Shares one VTP translation service port among N_PORTS pipeline shims.
// Requests are arbitrated round-robin. Each granted request gets the
// lowest-index free service tag, and {port, original tag} is kept in a tag
// table. Responses can return out of order. Each one is routed back to the
// originating port with the original tag restored.
//
// Ports
//   i_clk, i_reset               clock, synchronous active-high reset
//   i_port_req_*                 per-port request (en, pageVA, isSpeculative, tag), flattened
//   o_port_req_rdy               per-port grant (combinational)
//   o_port_rsp_*                 per-port response (en, pagePA, error, isBigPage, mayCache, tag)
//   o_svc_req_*, i_svc_req_rdy   registered request to the shared service
//   i_svc_rsp_*                  service response; tag field is the service tag
//   o_tags_busy                  number of allocated service tags
//   o_idle                       no tags allocated and no output valid
module mpf_vtp_svc_tag_arb #(
    parameter int N_PORTS    = 4,
    parameter int N_SVC_TAGS = 32,
    parameter int VA_W       = 36,
    parameter int PA_W       = 36,
    parameter int PORT_TAG_W = 8,
    localparam int SVC_TAG_W  = $clog2(N_SVC_TAGS),
    localparam int PORT_IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [N_PORTS-1:0]            i_port_req_en,
    input  logic [N_PORTS*VA_W-1:0]       i_port_req_page_va,
    input  logic [N_PORTS-1:0]            i_port_req_is_speculative,
    input  logic [N_PORTS*PORT_TAG_W-1:0] i_port_req_tag,
    output logic [N_PORTS-1:0]            o_port_req_rdy,
    output logic [N_PORTS-1:0]            o_port_rsp_en,
    output logic [N_PORTS*PA_W-1:0]       o_port_rsp_page_pa,
    output logic [N_PORTS-1:0]            o_port_rsp_error,
    output logic [N_PORTS-1:0]            o_port_rsp_is_big_page,
    output logic [N_PORTS-1:0]            o_port_rsp_may_cache,
    output logic [N_PORTS*PORT_TAG_W-1:0] o_port_rsp_tag,
    output logic                          o_svc_req_en,
    output logic [VA_W-1:0]               o_svc_req_page_va,
    output logic                          o_svc_req_is_speculative,
    output logic [SVC_TAG_W-1:0]          o_svc_req_tag,
    input  logic                          i_svc_req_rdy,
    input  logic                          i_svc_rsp_en,
    input  logic [PA_W-1:0]               i_svc_rsp_page_pa,
    input  logic                          i_svc_rsp_error,
    input  logic                          i_svc_rsp_is_big_page,
    input  logic                          i_svc_rsp_may_cache,
    input  logic [SVC_TAG_W-1:0]          i_svc_rsp_tag,
    output logic [SVC_TAG_W:0]            o_tags_busy,
    output logic                          o_idle
);

    logic [N_SVC_TAGS-1:0] r_free;
    logic [PORT_IDX_W-1:0] r_ptr;
    logic [SVC_TAG_W:0]    r_tags_busy;

    logic [PORT_IDX_W-1:0] r_tbl_port [N_SVC_TAGS];
    logic [PORT_TAG_W-1:0] r_tbl_tag  [N_SVC_TAGS];

    logic                  r_svc_req_en;
    logic [VA_W-1:0]       r_svc_req_va;
    logic                  r_svc_req_spec;
    logic [SVC_TAG_W-1:0]  r_svc_req_tag;

    logic [N_PORTS-1:0]    r_port_rsp_en;
    logic [PA_W-1:0]       r_rsp_pa;
    logic                  r_rsp_error;
    logic                  r_rsp_big;
    logic                  r_rsp_may_cache;
    logic [PORT_TAG_W-1:0] r_rsp_tag;

    logic                  w_gnt_any;
    logic [PORT_IDX_W-1:0] w_gnt_port;
    logic                  w_grant;
    logic [PORT_IDX_W-1:0] w_ptr_nxt;
    int                    w_best;
    int                    w_dist;
    logic [SVC_TAG_W-1:0]  w_alloc_tag;
    logic [N_SVC_TAGS-1:0] w_alloc_mask;
    logic [N_SVC_TAGS-1:0] w_free_mask;
    logic                  w_rsp_vld;
    logic                  w_free_busy;
    logic [N_PORTS-1:0]    w_rsp_onehot;
    logic [VA_W-1:0]       w_sel_va;
    logic                  w_sel_spec;
    logic [PORT_TAG_W-1:0] w_sel_tag;

    // Round-robin pick: smallest forward distance from r_ptr among requesters.
    always_comb begin
        w_gnt_any  = 1'b0;
        w_gnt_port = '0;
        w_best     = N_PORTS;
        w_dist     = 0;
        for (int p = 0; p < N_PORTS; p++) begin
            w_dist = p - int'(r_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + N_PORTS;
            end
            if (i_port_req_en[p] && (w_dist < w_best)) begin
                w_best     = w_dist;
                w_gnt_port = PORT_IDX_W'(p);
                w_gnt_any  = 1'b1;
            end
        end
        w_grant = w_gnt_any && i_svc_req_rdy && (|r_free) && !i_reset;
    end

    always_comb begin
        if (w_gnt_port == PORT_IDX_W'(N_PORTS - 1)) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = w_gnt_port + 1'b1;
        end
    end

    always_comb begin
        w_sel_va   = '0;
        w_sel_spec = 1'b0;
        w_sel_tag  = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            o_port_req_rdy[p] = w_grant && (w_gnt_port == PORT_IDX_W'(p));
            if (w_gnt_port == PORT_IDX_W'(p)) begin
                w_sel_va   = i_port_req_page_va[p*VA_W +: VA_W];
                w_sel_spec = i_port_req_is_speculative[p];
                w_sel_tag  = i_port_req_tag[p*PORT_TAG_W +: PORT_TAG_W];
            end
        end
    end

    // Lowest-index free tag: scan downward so the last hit wins.
    always_comb begin
        w_alloc_tag = '0;
        for (int t = N_SVC_TAGS - 1; t >= 0; t--) begin
            if (r_free[t]) begin
                w_alloc_tag = SVC_TAG_W'(t);
            end
        end
        w_alloc_mask = '0;
        if (w_grant) begin
            w_alloc_mask[w_alloc_tag] = 1'b1;
        end
    end

    // Freeing a tag that is already free leaves the bitmap unchanged, but the
    // response is still routed from whatever the table holds.
    always_comb begin
        w_rsp_vld   = i_svc_rsp_en && !i_reset;
        w_free_busy = w_rsp_vld && !r_free[i_svc_rsp_tag];
        w_free_mask = '0;
        if (w_rsp_vld) begin
            w_free_mask[i_svc_rsp_tag] = 1'b1;
        end
        for (int p = 0; p < N_PORTS; p++) begin
            w_rsp_onehot[p] = w_rsp_vld && (r_tbl_port[i_svc_rsp_tag] == PORT_IDX_W'(p));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_free        <= '1;
            r_ptr         <= '0;
            r_tags_busy   <= '0;
            r_svc_req_en  <= 1'b0;
            r_port_rsp_en <= '0;
        end else begin
            // Allocation sees the bitmap from the start of the cycle, so a tag
            // freed this cycle only becomes allocatable next cycle.
            r_free        <= (r_free & ~w_alloc_mask) | w_free_mask;
            r_svc_req_en  <= w_grant;
            r_port_rsp_en <= w_rsp_onehot;
            if (w_grant) begin
                r_ptr <= w_ptr_nxt;
            end
            if (w_grant && !w_free_busy) begin
                r_tags_busy <= r_tags_busy + 1'b1;
            end else if (!w_grant && w_free_busy) begin
                r_tags_busy <= r_tags_busy - 1'b1;
            end
        end
    end

    // Table and payload registers carry no reset; they are qualified by the
    // valid bits above.
    always_ff @(posedge i_clk) begin
        if (w_grant) begin
            r_tbl_port[w_alloc_tag] <= w_gnt_port;
            r_tbl_tag[w_alloc_tag]  <= w_sel_tag;
            r_svc_req_va            <= w_sel_va;
            r_svc_req_spec          <= w_sel_spec;
            r_svc_req_tag           <= w_alloc_tag;
        end
        if (w_rsp_vld) begin
            r_rsp_pa        <= i_svc_rsp_page_pa;
            r_rsp_error     <= i_svc_rsp_error;
            r_rsp_big       <= i_svc_rsp_is_big_page;
            r_rsp_may_cache <= i_svc_rsp_may_cache;
            r_rsp_tag       <= r_tbl_tag[i_svc_rsp_tag];
        end
    end

    always @(posedge i_clk) begin
        if (!i_reset && i_svc_rsp_en) begin
            assert (!r_free[i_svc_rsp_tag]);
        end
    end

    // Only one response exists per cycle, so the payload is shared by all
    // ports and qualified per port by o_port_rsp_en.
    assign o_port_rsp_en          = r_port_rsp_en;
    assign o_port_rsp_page_pa     = {N_PORTS{r_rsp_pa}};
    assign o_port_rsp_error       = {N_PORTS{r_rsp_error}};
    assign o_port_rsp_is_big_page = {N_PORTS{r_rsp_big}};
    assign o_port_rsp_may_cache   = {N_PORTS{r_rsp_may_cache}};
    assign o_port_rsp_tag         = {N_PORTS{r_rsp_tag}};

    assign o_svc_req_en             = r_svc_req_en;
    assign o_svc_req_page_va        = r_svc_req_va;
    assign o_svc_req_is_speculative = r_svc_req_spec;
    assign o_svc_req_tag            = r_svc_req_tag;

    assign o_tags_busy = r_tags_busy;
    assign o_idle      = (r_tags_busy == '0) && !r_svc_req_en && !(|r_port_rsp_en);

endmodule

// File: tb/tb_mpf_vtp_svc_tag_arb.sv
module tb_mpf_vtp_svc_tag_arb;
    localparam int NP   = 4;
    localparam int NT   = 32;
    localparam int VA_W = 36;
    localparam int PA_W = 36;
    localparam int PTW  = 8;
    localparam int STW  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                i_reset;
    logic [NP-1:0]       i_port_req_en;
    logic [NP*VA_W-1:0]  i_port_req_page_va;
    logic [NP-1:0]       i_port_req_is_speculative;
    logic [NP*PTW-1:0]   i_port_req_tag;
    logic [NP-1:0]       o_port_req_rdy;
    logic [NP-1:0]       o_port_rsp_en;
    logic [NP*PA_W-1:0]  o_port_rsp_page_pa;
    logic [NP-1:0]       o_port_rsp_error;
    logic [NP-1:0]       o_port_rsp_is_big_page;
    logic [NP-1:0]       o_port_rsp_may_cache;
    logic [NP*PTW-1:0]   o_port_rsp_tag;
    logic                o_svc_req_en;
    logic [VA_W-1:0]     o_svc_req_page_va;
    logic                o_svc_req_is_speculative;
    logic [STW-1:0]      o_svc_req_tag;
    logic                i_svc_req_rdy;
    logic                i_svc_rsp_en;
    logic [PA_W-1:0]     i_svc_rsp_page_pa;
    logic                i_svc_rsp_error;
    logic                i_svc_rsp_is_big_page;
    logic                i_svc_rsp_may_cache;
    logic [STW-1:0]      i_svc_rsp_tag;
    logic [STW:0]        o_tags_busy;
    logic                o_idle;

    mpf_vtp_svc_tag_arb #(
        .N_PORTS(NP), .N_SVC_TAGS(NT), .VA_W(VA_W), .PA_W(PA_W), .PORT_TAG_W(PTW)
    ) dut (
        .i_clk                    (clk),
        .i_reset                  (i_reset),
        .i_port_req_en            (i_port_req_en),
        .i_port_req_page_va       (i_port_req_page_va),
        .i_port_req_is_speculative(i_port_req_is_speculative),
        .i_port_req_tag           (i_port_req_tag),
        .o_port_req_rdy           (o_port_req_rdy),
        .o_port_rsp_en            (o_port_rsp_en),
        .o_port_rsp_page_pa       (o_port_rsp_page_pa),
        .o_port_rsp_error         (o_port_rsp_error),
        .o_port_rsp_is_big_page   (o_port_rsp_is_big_page),
        .o_port_rsp_may_cache     (o_port_rsp_may_cache),
        .o_port_rsp_tag           (o_port_rsp_tag),
        .o_svc_req_en             (o_svc_req_en),
        .o_svc_req_page_va        (o_svc_req_page_va),
        .o_svc_req_is_speculative (o_svc_req_is_speculative),
        .o_svc_req_tag            (o_svc_req_tag),
        .i_svc_req_rdy            (i_svc_req_rdy),
        .i_svc_rsp_en             (i_svc_rsp_en),
        .i_svc_rsp_page_pa        (i_svc_rsp_page_pa),
        .i_svc_rsp_error          (i_svc_rsp_error),
        .i_svc_rsp_is_big_page    (i_svc_rsp_is_big_page),
        .i_svc_rsp_may_cache      (i_svc_rsp_may_cache),
        .i_svc_rsp_tag            (i_svc_rsp_tag),
        .o_tags_busy              (o_tags_busy),
        .o_idle                   (o_idle)
    );

    logic [VA_W-1:0] pr_va   [NP];
    logic            pr_spec [NP];
    logic [PTW-1:0]  pr_tag  [NP];

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            i_port_req_page_va[p*VA_W +: VA_W]   = pr_va[p];
            i_port_req_is_speculative[p]         = pr_spec[p];
            i_port_req_tag[p*PTW +: PTW]         = pr_tag[p];
        end
    end

    // Reference model: set of free tags, owner table, round-robin pointer.
    bit              m_free     [NT];
    int              m_tbl_port [NT];
    logic [PTW-1:0]  m_tbl_tag  [NT];
    int              m_ptr;
    int              m_busy;
    bit              e_svc_en;
    logic [VA_W-1:0] e_svc_va;
    bit              e_svc_spec;
    int              e_svc_tag;
    int              e_rsp_port;
    logic [PTW-1:0]  e_rsp_tag;
    logic [PA_W-1:0] e_rsp_pa;
    logic [2:0]      e_rsp_flags;

    logic            g_rst, g_rdy, g_rsp_en;
    logic [NP-1:0]   g_req;
    int              g_rsp_tag;
    int              g_gp;

    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < NT; t++) m_free[t] = 1'b1;
        m_ptr = 0;
        m_busy = 0;
        e_svc_en = 1'b0;
        e_rsp_port = -1;
    endtask

    // Drive one cycle's inputs, then check DUT against the model.
    task automatic drive_and_check(input logic rst, input logic [NP-1:0] req, input logic rdy,
                                   input logic rsp_en, input int rsp_tag, input logic [PA_W-1:0] pa,
                                   input logic [2:0] flags);
        logic [NP-1:0] exp_rdy;
        logic [NP-1:0] exp_rsp_en;
        int p;
        bit found;
        i_reset = rst;
        i_port_req_en = req;
        i_svc_req_rdy = rdy;
        i_svc_rsp_en = rsp_en;
        i_svc_rsp_tag = STW'(rsp_tag);
        i_svc_rsp_page_pa = pa;
        {i_svc_rsp_error, i_svc_rsp_is_big_page, i_svc_rsp_may_cache} = flags;
        g_rst = rst; g_req = req; g_rdy = rdy; g_rsp_en = rsp_en; g_rsp_tag = rsp_tag;
        #2;
        g_gp = -1;
        found = 1'b0;
        if (!rst && rdy && m_busy < NT) begin
            for (int k = 0; k < NP; k++) begin
                p = (m_ptr + k) % NP;
                if (!found && req[p]) begin
                    g_gp = p;
                    found = 1'b1;
                end
            end
        end
        exp_rdy = '0;
        if (g_gp >= 0) exp_rdy[g_gp] = 1'b1;
        chk("port_req_rdy", o_port_req_rdy, exp_rdy);
        chk("svc_req_en", o_svc_req_en, e_svc_en);
        if (e_svc_en) begin
            chk("svc_req_fields", {o_svc_req_tag, o_svc_req_is_speculative, o_svc_req_page_va},
                {STW'(e_svc_tag), e_svc_spec, e_svc_va});
        end
        exp_rsp_en = '0;
        if (e_rsp_port >= 0) exp_rsp_en[e_rsp_port] = 1'b1;
        chk("port_rsp_en", o_port_rsp_en, exp_rsp_en);
        if (e_rsp_port >= 0) begin
            chk("port_rsp_fields",
                {o_port_rsp_tag[e_rsp_port*PTW +: PTW], o_port_rsp_page_pa[e_rsp_port*PA_W +: PA_W],
                 o_port_rsp_error[e_rsp_port], o_port_rsp_is_big_page[e_rsp_port],
                 o_port_rsp_may_cache[e_rsp_port]},
                {e_rsp_tag, e_rsp_pa, e_rsp_flags});
        end
        chk("tags_busy", o_tags_busy, m_busy);
        chk("idle", o_idle, (m_busy == 0) && !e_svc_en && (e_rsp_port < 0));
        p = 0;
    endtask

    // Advance the model by one cycle and move to the next cycle.
    task automatic advance();
        int at;
        bit got;
        if (g_rst) begin
            model_reset();
        end else begin
            e_rsp_port = -1;
            if (g_rsp_en) begin
                e_rsp_port  = m_tbl_port[g_rsp_tag];
                e_rsp_tag   = m_tbl_tag[g_rsp_tag];
                e_rsp_pa    = i_svc_rsp_page_pa;
                e_rsp_flags = {i_svc_rsp_error, i_svc_rsp_is_big_page, i_svc_rsp_may_cache};
            end
            e_svc_en = 1'b0;
            if (g_gp >= 0) begin
                got = 1'b0;
                at = 0;
                for (int t = 0; t < NT; t++) begin
                    if (!got && m_free[t]) begin
                        at = t;
                        got = 1'b1;
                    end
                end
                m_free[at] = 1'b0;
                m_tbl_port[at] = g_gp;
                m_tbl_tag[at] = pr_tag[g_gp];
                e_svc_en = 1'b1;
                e_svc_tag = at;
                e_svc_va = pr_va[g_gp];
                e_svc_spec = pr_spec[g_gp];
                m_busy++;
                m_ptr = (g_gp + 1) % NP;
            end
            if (g_rsp_en && !m_free[g_rsp_tag]) begin
                m_free[g_rsp_tag] = 1'b1;
                m_busy--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic rst, input logic [NP-1:0] req, input logic rdy,
                         input logic rsp_en, input int rsp_tag, input logic [PA_W-1:0] pa,
                         input logic [2:0] flags);
        drive_and_check(rst, req, rdy, rsp_en, rsp_tag, pa, flags);
        advance();
    endtask

    typedef struct {
        logic          rst;
        logic [NP-1:0] req;
        logic          rdy;
        logic          rsp_en;
        int            rsp_tag;
        logic [PA_W-1:0] pa;
        logic [NP-1:0] exp_rdy;
        int            exp_svc_tag;   // -1: svc_req_en low
        int            exp_rsp_port;  // -1: no response
        logic [PTW-1:0] exp_rsp_tag;
        logic [PA_W-1:0] exp_rsp_pa;
        int            exp_busy;
    } vec_t;

    vec_t vt[15];
    int ord[8];
    int blist[$];

    initial begin
        i_reset = 1'b1;
        i_port_req_en = '0;
        i_svc_req_rdy = 1'b1;
        i_svc_rsp_en = 1'b0;
        i_svc_rsp_tag = '0;
        i_svc_rsp_page_pa = '0;
        {i_svc_rsp_error, i_svc_rsp_is_big_page, i_svc_rsp_may_cache} = 3'b000;
        for (int p = 0; p < NP; p++) begin
            pr_va[p] = VA_W'(36'h100 * (p + 1));
            pr_spec[p] = p[0];
            pr_tag[p] = PTW'(8'h40 + p);
        end
        pr_va[2] = 36'h1234;
        pr_tag[2] = 8'd5;
        model_reset();
        @(posedge clk);
        #1;

        //          rst  req      rdy  rsp tag pa        exp_rdy  svc  rport rtag  rpa     busy
        vt[0]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 0, 36'h0,   4'b0000, -1, -1, 8'd0, 36'h0,   0};
        vt[1]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 0, 36'h0,   4'b0100, -1, -1, 8'd0, 36'h0,   0};
        vt[2]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 0, 36'h0,   4'b0000,  0, -1, 8'd0, 36'h0,   1};
        vt[3]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 0, 36'hABC, 4'b0000, -1, -1, 8'd0, 36'h0,   1};
        vt[4]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 0, 36'h0,   4'b0000, -1,  2, 8'd5, 36'hABC, 0};
        vt[5]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 0, 36'h0,   4'b0000, -1, -1, 8'd0, 36'h0,   0};
        vt[6]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 0, 36'h0,   4'b0001, -1, -1, 8'd0, 36'h0,   0};
        vt[7]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 0, 36'h0,   4'b0010,  0, -1, 8'd0, 36'h0,   1};
        vt[8]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 0, 36'h0,   4'b0100,  1, -1, 8'd0, 36'h0,   2};
        vt[9]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 0, 36'h0,   4'b1000,  2, -1, 8'd0, 36'h0,   3};
        vt[10] = '{1'b0, 4'b1111, 1'b1, 1'b0, 0, 36'h0,   4'b0001,  3, -1, 8'd0, 36'h0,   4};
        vt[11] = '{1'b0, 4'b1111, 1'b0, 1'b0, 0, 36'h0,   4'b0000,  4, -1, 8'd0, 36'h0,   5};
        vt[12] = '{1'b0, 4'b0000, 1'b1, 1'b0, 0, 36'h0,   4'b0000, -1, -1, 8'd0, 36'h0,   5};
        vt[13] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2, 36'h55,  4'b0000, -1, -1, 8'd0, 36'h0,   5};
        vt[14] = '{1'b0, 4'b0000, 1'b1, 1'b0, 0, 36'h0,   4'b0000, -1,  2, 8'd5, 36'h55,  4};

        for (int i = 0; i < 15; i++) begin
            drive_and_check(vt[i].rst, vt[i].req, vt[i].rdy, vt[i].rsp_en, vt[i].rsp_tag,
                            vt[i].pa, 3'b000);
            chk($sformatf("tbl%0d_rdy", i), o_port_req_rdy, vt[i].exp_rdy);
            chk($sformatf("tbl%0d_svc_en", i), o_svc_req_en, vt[i].exp_svc_tag >= 0);
            if (vt[i].exp_svc_tag >= 0)
                chk($sformatf("tbl%0d_svc_tag", i), o_svc_req_tag, vt[i].exp_svc_tag);
            if (vt[i].exp_rsp_port < 0) begin
                chk($sformatf("tbl%0d_rsp_en", i), o_port_rsp_en, 0);
            end else begin
                chk($sformatf("tbl%0d_rsp_en", i), o_port_rsp_en, 1 << vt[i].exp_rsp_port);
                chk($sformatf("tbl%0d_rsp_tag", i), o_port_rsp_tag[vt[i].exp_rsp_port*PTW +: PTW],
                    vt[i].exp_rsp_tag);
                chk($sformatf("tbl%0d_rsp_pa", i),
                    o_port_rsp_page_pa[vt[i].exp_rsp_port*PA_W +: PA_W], vt[i].exp_rsp_pa);
            end
            chk($sformatf("tbl%0d_busy", i), o_tags_busy, vt[i].exp_busy);
            advance();
        end

        // Exhaustion: 32 grants, the 33rd stalls until tag 17 returns.
        cycle(1'b1, 4'b0000, 1'b1, 1'b0, 0, '0, 3'b000);
        for (int i = 0; i < NT; i++) cycle(1'b0, 4'b1111, 1'b1, 1'b0, 0, '0, 3'b000);
        drive_and_check(1'b0, 4'b1111, 1'b1, 1'b0, 0, '0, 3'b000);
        chk("exh_stall_rdy", o_port_req_rdy, 0);
        chk("exh_busy_full", o_tags_busy, NT);
        advance();
        drive_and_check(1'b0, 4'b1111, 1'b1, 1'b1, 17, 36'h777, 3'b101);
        chk("exh_free_cycle_rdy", o_port_req_rdy, 0);
        advance();
        drive_and_check(1'b0, 4'b1111, 1'b1, 1'b0, 0, '0, 3'b000);
        chk("exh_regrant_rdy", o_port_req_rdy, 4'b0001);
        advance();
        drive_and_check(1'b0, 4'b0000, 1'b1, 1'b0, 0, '0, 3'b000);
        chk("exh_regrant_tag", o_svc_req_tag, 17);
        chk("exh_regrant_en", o_svc_req_en, 1);
        advance();
        for (int t = NT - 1; t >= 0; t--)
            cycle(1'b0, 4'b0000, 1'b1, 1'b1, t, PA_W'(t * 3), 3'(t));
        cycle(1'b0, 4'b0000, 1'b1, 1'b0, 0, '0, 3'b000);

        // Out-of-order: 8 requests from mixed ports, responses in reverse order.
        ord = '{1, 3, 0, 2, 2, 1, 3, 0};
        for (int i = 0; i < 8; i++) begin
            pr_tag[ord[i]] = PTW'(8'h10 + i);
            pr_va[ord[i]] = VA_W'(36'hA000 + i);
            cycle(1'b0, 4'b0001 << ord[i], 1'b1, 1'b0, 0, '0, 3'b000);
        end
        for (int i = 0; i <= 8; i++) begin
            if (i < 8)
                drive_and_check(1'b0, 4'b0000, 1'b1, 1'b1, 7 - i, PA_W'(36'hF00 + i), 3'(i));
            else
                drive_and_check(1'b0, 4'b0000, 1'b1, 1'b0, 0, '0, 3'b000);
            if (i > 0) begin
                chk("ooo_rsp_port", o_port_rsp_en, 4'b0001 << ord[8 - i]);
                chk("ooo_rsp_tag", o_port_rsp_tag[ord[8 - i]*PTW +: PTW], 8'h10 + 8 - i);
            end
            advance();
        end

        // Simultaneous alloc/free, then svc_req_rdy low for 5 cycles.
        cycle(1'b1, 4'b0000, 1'b1, 1'b0, 0, '0, 3'b000);
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0001, 1'b1, 1'b0, 0, '0, 3'b000);
        drive_and_check(1'b0, 4'b0001, 1'b1, 1'b1, 3, 36'h333, 3'b010);
        chk("simul_rdy", o_port_req_rdy, 4'b0001);
        advance();
        drive_and_check(1'b0, 4'b0000, 1'b1, 1'b0, 0, '0, 3'b000);
        chk("simul_tag", o_svc_req_tag, 5);
        chk("simul_busy", o_tags_busy, 5);
        advance();
        cycle(1'b0, 4'b1111, 1'b1, 1'b0, 0, '0, 3'b000);
        for (int i = 0; i < 5; i++) begin
            drive_and_check(1'b0, 4'b1111, 1'b0, 1'b0, 0, '0, 3'b000);
            chk("norady_rdy", o_port_req_rdy, 0);
            chk("norady_svc_en", o_svc_req_en, i == 0);
            advance();
        end

        // Reset with 10 tags outstanding.
        cycle(1'b1, 4'b0000, 1'b1, 1'b0, 0, '0, 3'b000);
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'b1111, 1'b1, 1'b0, 0, '0, 3'b000);
        drive_and_check(1'b1, 4'b1111, 1'b1, 1'b1, 4, 36'h444, 3'b111);
        chk("rst_busy_before", o_tags_busy, 10);
        advance();
        drive_and_check(1'b0, 4'b1111, 1'b1, 1'b0, 0, '0, 3'b000);
        chk("rst_busy_after", o_tags_busy, 0);
        chk("rst_idle_after", o_idle, 1);
        chk("rst_first_rdy", o_port_req_rdy, 4'b0001);
        advance();
        drive_and_check(1'b0, 4'b0000, 1'b1, 1'b0, 0, '0, 3'b000);
        chk("rst_first_tag", o_svc_req_tag, 0);
        advance();

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            logic rsp_en;
            int rtag;
            for (int p = 0; p < NP; p++) begin
                pr_va[p] = VA_W'({$urandom, $urandom});
                pr_spec[p] = $urandom_range(0, 1) == 1;
                pr_tag[p] = PTW'($urandom);
            end
            blist.delete();
            for (int t = 0; t < NT; t++) if (!m_free[t]) blist.push_back(t);
            rsp_en = (blist.size() > 0) && ($urandom_range(0, 2) != 0);
            rtag = rsp_en ? blist[$urandom_range(0, blist.size() - 1)] : 0;
            cycle($urandom_range(0, 299) == 0, NP'($urandom_range(0, 15)),
                  $urandom_range(0, 7) != 0, rsp_en, rtag,
                  PA_W'({$urandom, $urandom}), 3'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
